// File: rtl/serial_burst_slave.sv
// ============================================================================
// serial_burst_slave
// ----------------------------------------------------------------------------
// Bit-serial bus slave in front of an N-bit x MEM_WORDS block RAM.
// A frame is: ADN address bits, BL_BITS burst-length bits (burst = field+1
// words), then N-bit write words on data_in, or N-bit read words returned on
// data_out. Bursts run at consecutive addresses, wrapping MEM_WORDS-1 -> 0.
// A start address >= MEM_WORDS is flagged on err with the done pulse. Such a
// frame still runs to full length: writes are dropped and reads return zeros.
// All fields travel MSB first.
//
// Parameters
//   N          data word width (>= 2)
//   MEM_WORDS  memory depth (<= 2**ADN)
//   ADN        serial address field length (>= 2)
//   BL_BITS    burst field length (>= 1)
//
// Ports
//   clk        single clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   valid_in   master presents a frame bit this cycle
//   wren       1 = write frame, 0 = read frame; sampled on the first bit only
//   addr_in    serial address / burst-length bit
//   data_in    serial write-data bit
//   ready      slave idle and able to take a new frame (combinational)
//   valid_out  data_out carries a read bit this cycle
//   data_out   serial read-data bit
//   done       one-cycle pulse when a frame completes
//   err        start address was out of range; meaningful only with done
// ============================================================================
module serial_burst_slave #(
    parameter int N         = 8,
    parameter int MEM_WORDS = 2048,
    parameter int ADN       = 12,
    parameter int BL_BITS   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    input  logic wren,
    input  logic addr_in,
    input  logic data_in,
    output logic ready,
    output logic valid_out,
    output logic data_out,
    output logic done,
    output logic err
);

    // One counter serves every field, so it is sized for the longest field.
    localparam int CNT_MAX = (ADN > N) ? ((ADN > BL_BITS) ? ADN : BL_BITS)
                                       : ((N   > BL_BITS) ? N   : BL_BITS);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int RW = BL_BITS + 1;
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_WDATA,
        S_WCOMMIT,
        S_RFETCH,
        S_RDATA
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CW-1:0]      cnt;
    logic [ADN-1:0]     addr;
    logic [BL_BITS-1:0] blen;
    logic [RW-1:0]      remaining;
    logic               wr;
    logic               oor;
    logic [N-1:0]       wword;
    logic [N-1:0]       shreg;

    logic [N-1:0]       mem [MEM_WORDS];

    // Field-boundary and datapath helpers shared by both processes.
    logic               addr_last;
    logic               burst_last;
    logic               word_end;
    logic               last_word;
    logic [ADN-1:0]     addr_shift;
    logic [ADN-1:0]     addr_inc;
    logic [BL_BITS-1:0] blen_shift;
    logic [N-1:0]       wword_shift;
    logic               addr_oor;
    logic               mem_we;

    assign addr_last   = (cnt == CW'(ADN - 1));
    assign burst_last  = (cnt == CW'(BL_BITS - 1));
    assign word_end    = (cnt == CW'(N - 1));
    assign last_word   = (remaining == RW'(1));
    assign addr_shift  = (addr << 1) | ADN'(addr_in);
    assign blen_shift  = (blen << 1) | BL_BITS'(addr_in);
    assign wword_shift = (wword << 1) | N'(data_in);
    // Wrap explicitly at MEM_WORDS-1, which need not be a power of two.
    assign addr_inc    = (addr == ADN'(MEM_WORDS - 1)) ? '0 : addr + ADN'(1);
    // Extra MSB keeps the compare valid when MEM_WORDS == 2**ADN.
    assign addr_oor    = ({1'b0, addr} >= (ADN + 1)'(MEM_WORDS));
    assign mem_we      = (state == S_WCOMMIT) && !oor && !rst;

    assign ready = (state == S_IDLE) && !rst;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next is given a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (valid_in)              state_next = S_ADDR;
            S_ADDR:    if (valid_in && addr_last) state_next = S_BURST;
            S_BURST:   if (valid_in && burst_last)
                           state_next = wr ? S_WDATA : S_RFETCH;
            S_WDATA:   if (valid_in && word_end)  state_next = S_WCOMMIT;
            S_WCOMMIT: state_next = last_word ? S_IDLE : S_WDATA;
            S_RFETCH:  state_next = S_RDATA;
            S_RDATA:   if (word_end) state_next = last_word ? S_IDLE : S_RFETCH;
            default:   state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM write port
    // ------------------------------------------------------------------
    // NOTE: the RAM array has no reset so it maps onto block RAM; only the
    // control path is cleared by rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr[AW-1:0]] <= wword;
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            addr      <= '0;
            blen      <= '0;
            remaining <= '0;
            wr        <= 1'b0;
            oor       <= 1'b0;
            wword     <= '0;
            shreg     <= '0;
            valid_out <= 1'b0;
            data_out  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Output strobes are single-cycle unless a state re-asserts them.
            valid_out <= 1'b0;
            data_out  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;

            case (state)
                S_IDLE: begin
                    // The first address bit is taken here, not dropped.
                    if (valid_in) begin
                        addr <= ADN'(addr_in);
                        wr   <= wren;
                        cnt  <= CW'(1);
                    end
                end

                S_ADDR: begin
                    if (valid_in) begin
                        addr <= addr_shift;
                        cnt  <= addr_last ? '0 : cnt + CW'(1);
                    end
                end

                S_BURST: begin
                    if (valid_in) begin
                        blen <= blen_shift;
                        cnt  <= burst_last ? '0 : cnt + CW'(1);
                        if (burst_last) begin
                            remaining <= RW'(blen_shift) + RW'(1);
                            oor       <= addr_oor;
                        end
                    end
                end

                S_WDATA: begin
                    if (valid_in) begin
                        wword <= wword_shift;
                        cnt   <= word_end ? '0 : cnt + CW'(1);
                    end
                end

                S_WCOMMIT: begin
                    addr      <= addr_inc;
                    remaining <= remaining - RW'(1);
                    if (last_word) begin
                        done <= 1'b1;
                        err  <= oor;
                    end
                end

                S_RFETCH: begin
                    // Out-of-range frames stream zeros instead of aliased RAM data.
                    shreg <= oor ? '0 : mem[addr[AW-1:0]];
                    cnt   <= '0;
                end

                S_RDATA: begin
                    valid_out <= 1'b1;
                    data_out  <= shreg[N-1];
                    shreg     <= shreg << 1;
                    cnt       <= word_end ? '0 : cnt + CW'(1);
                    if (word_end) begin
                        addr      <= addr_inc;
                        remaining <= remaining - RW'(1);
                        if (last_word) begin
                            done <= 1'b1;
                            err  <= oor;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_burst_slave.sv
// ============================================================================
// tb_serial_burst_slave
// ----------------------------------------------------------------------------
// Self-checking bench for serial_burst_slave (N=8, MEM_WORDS=2048, ADN=12,
// BL_BITS=2). A table of directed frames is followed by a reset-abort
// sequence, then random write/read-back frame pairs checked against a plain
// array model of the RAM. Inputs change on the falling edge and outputs are
// sampled on the falling edge.
// ============================================================================
module tb_serial_burst_slave;

    localparam int N   = 8;
    localparam int MW  = 2048;
    localparam int ADN = 12;
    localparam int BLB = 2;

    logic clk = 1'b0;
    logic rst, valid_in, wren, addr_in, data_in;
    logic ready, valid_out, data_out, done, err;

    always #5 clk = ~clk;

    serial_burst_slave #(.N(N), .MEM_WORDS(MW), .ADN(ADN), .BL_BITS(BLB)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .wren      (wren),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .ready     (ready),
        .valid_out (valid_out),
        .data_out  (data_out),
        .done      (done),
        .err       (err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- bus monitor state ----------------
    int  cyc = 0;
    int  done_cnt;
    int  done_cyc;
    logic err_at_done;
    int  ready_bad;
    bit  in_frame = 1'b0;
    int  hdr_cyc;
    int  wlast_cyc;
    bit  rbits[$];
    int  vcyc[$];

    // RAM model: contents plus a written-flag so only defined words are compared.
    logic [7:0] mem_model [MW];
    bit         known     [MW];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            err_at_done = err;
            done_cyc    = cyc;
        end else if (in_frame && done_cnt == 0 && ready !== 1'b0) begin
            ready_bad++;
        end
        if (valid_out === 1'b1) begin
            rbits.push_back(data_out);
            vcyc.push_back(cyc);
        end
    endtask

    task automatic idle_tick();
        valid_in = 1'b0;
        addr_in  = 1'($urandom);
        data_in  = 1'($urandom);
        wren     = 1'($urandom);
        tick();
    endtask

    // mode 0: back-to-back bits, 1: valid_in toggles 1/0, 2: random 0..2 idle cycles
    function automatic int gap_len(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    task automatic run_frame(input bit wr, input logic [11:0] a, input logic [1:0] bl,
                             input logic [31:0] wpk, input int mode);
        logic       hb[$];
        logic [7:0] w;
        int         ng;
        done_cnt = 0; ready_bad = 0; err_at_done = 1'bx;
        rbits.delete(); vcyc.delete();
        in_frame = 1'b1;
        for (int i = ADN - 1; i >= 0; i--) hb.push_back(a[i]);
        for (int i = BLB - 1; i >= 0; i--) hb.push_back(bl[i]);
        foreach (hb[k]) begin
            valid_in = 1'b1;
            addr_in  = hb[k];
            wren     = wr;
            data_in  = 1'($urandom);
            tick();
            hdr_cyc = cyc;
            ng = gap_len(mode);
            repeat (ng) idle_tick();
        end
        if (wr) begin
            for (int j = 0; j <= int'(bl); j++) begin
                w = wpk[31 - 8*j -: 8];
                for (int b = 7; b >= 0; b--) begin
                    valid_in = 1'b1;
                    data_in  = w[b];
                    addr_in  = 1'($urandom);
                    tick();
                    wlast_cyc = cyc;
                    ng = gap_len(mode);
                    // The commit cycle after each word needs a non-bit cycle.
                    if (b == 0 && ng == 0) ng = 1;
                    repeat (ng) idle_tick();
                end
            end
            for (int t = 0; t < 6 && done_cnt == 0; t++) idle_tick();
        end else begin
            // valid_in is ignored while the slave streams, so drive it randomly.
            for (int t = 0; t < 60 && done_cnt == 0; t++) begin
                valid_in = 1'($urandom);
                addr_in  = 1'($urandom);
                data_in  = 1'($urandom);
                wren     = 1'($urandom);
                tick();
            end
        end
        in_frame = 1'b0;
        repeat (2) idle_tick();
    endtask

    task automatic frame_checks(input string tag, input bit wr, input logic [1:0] bl,
                                input bit exp_err, input logic [31:0] exp_words);
        int         nw;
        bit         tim_ok;
        logic [7:0] got;
        nw = int'(bl) + 1;
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " err"}, 32'(err_at_done), 32'(exp_err));
        check({tag, " ready_low_in_frame"}, ready_bad, 0);
        if (wr) begin
            check({tag, " done_timing"}, done_cyc - wlast_cyc, 1);
        end else begin
            check({tag, " bit_count"}, rbits.size(), 8 * nw);
            if (rbits.size() == 8 * nw) begin
                for (int j = 0; j < nw; j++) begin
                    got = '0;
                    for (int b = 0; b < 8; b++) got = {got[6:0], rbits[8*j + b]};
                    check($sformatf("%s word%0d", tag, j), got, exp_words[31 - 8*j -: 8]);
                end
                // First bit two cycles after the last burst bit; one idle cycle between words.
                tim_ok = (vcyc[0] == hdr_cyc + 2);
                for (int i = 1; i < vcyc.size(); i++)
                    if (vcyc[i] - vcyc[i-1] != ((i % 8 == 0) ? 2 : 1)) tim_ok = 1'b0;
                if (done_cyc != vcyc[vcyc.size() - 1]) tim_ok = 1'b0;
                check({tag, " stream_timing"}, 32'(tim_ok), 1);
            end
        end
    endtask

    task automatic model_write(input logic [11:0] a, input logic [1:0] bl, input logic [31:0] wpk);
        int idx;
        if (int'(a) < MW) begin
            for (int j = 0; j <= int'(bl); j++) begin
                idx = (int'(a) + j) % MW;
                mem_model[idx] = wpk[31 - 8*j -: 8];
                known[idx]     = 1'b1;
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [1:0]  bl;
        logic [31:0] words;   // write data, or expected read data, word 0 in [31:24]
        int          mode;
        bit          exp_err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp;
        logic [11:0] ra;
        logic [1:0]  rbl;
        logic [31:0] rw;
        int          r;

        tbl[0]  = '{1'b1, 12'h005, 2'd0, 32'hA5000000, 0, 1'b0};
        tbl[1]  = '{1'b0, 12'h005, 2'd0, 32'hA5000000, 0, 1'b0};
        tbl[2]  = '{1'b1, 12'h7FF, 2'd1, 32'h11220000, 0, 1'b0};
        tbl[3]  = '{1'b0, 12'h7FF, 2'd0, 32'h11000000, 0, 1'b0};
        tbl[4]  = '{1'b0, 12'h000, 2'd0, 32'h22000000, 0, 1'b0};
        tbl[5]  = '{1'b1, 12'h010, 2'd3, 32'h01020304, 0, 1'b0};
        tbl[6]  = '{1'b0, 12'h010, 2'd3, 32'h01020304, 0, 1'b0};
        tbl[7]  = '{1'b1, 12'h100, 2'd0, 32'hC3000000, 0, 1'b0};
        tbl[8]  = '{1'b1, 12'h900, 2'd0, 32'h5A000000, 0, 1'b1};
        tbl[9]  = '{1'b0, 12'h900, 2'd0, 32'h00000000, 0, 1'b1};
        tbl[10] = '{1'b0, 12'h100, 2'd0, 32'hC3000000, 0, 1'b0};
        tbl[11] = '{1'b1, 12'h020, 2'd0, 32'hA5000000, 1, 1'b0};
        tbl[12] = '{1'b0, 12'h020, 2'd0, 32'hA5000000, 1, 1'b0};
        tbl[13] = '{1'b0, 12'h7FF, 2'd1, 32'h11220000, 2, 1'b0};

        foreach (known[i]) known[i] = 1'b0;

        // ---------------- reset state ----------------
        rst = 1'b1; valid_in = 1'b1; wren = 1'b1; addr_in = 1'b1; data_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(ready), 0);
        check("reset valid_out", 32'(valid_out), 0);
        check("reset data_out", 32'(data_out), 0);
        check("reset done", 32'(done), 0);
        check("reset err", 32'(err), 0);
        rst = 1'b0; valid_in = 1'b0;
        #1;
        check("ready after reset", 32'(ready), 1);
        @(negedge clk);

        // ---------------- directed table ----------------
        for (int i = 0; i < 14; i++) begin
            run_frame(tbl[i].wr, tbl[i].addr, tbl[i].bl, tbl[i].words, tbl[i].mode);
            frame_checks($sformatf("vec%0d", i), tbl[i].wr, tbl[i].bl, tbl[i].exp_err, tbl[i].words);
            if (tbl[i].wr) model_write(tbl[i].addr, tbl[i].bl, tbl[i].words);
        end

        // ---------------- reset mid-frame ----------------
        run_frame(1'b1, 12'h030, 2'd0, 32'h3C000000, 0);
        frame_checks("abort_pre", 1'b1, 2'd0, 1'b0, 32'h3C000000);
        model_write(12'h030, 2'd0, 32'h3C000000);
        done_cnt = 0;
        for (int i = ADN - 1; i >= 0; i--) begin
            valid_in = 1'b1; wren = 1'b1; addr_in = ADN'(12'h030) >> i;
            tick();
        end
        for (int i = BLB - 1; i >= 0; i--) begin
            valid_in = 1'b1; addr_in = 1'b0;
            tick();
        end
        repeat (4) begin
            valid_in = 1'b1; data_in = 1'b1;
            tick();
        end
        rst = 1'b1; valid_in = 1'b1; data_in = 1'b1;
        tick();
        check("abort ready_during_rst", 32'(ready), 0);
        check("abort valid_out", 32'(valid_out), 0);
        rst = 1'b0; valid_in = 1'b0;
        #1;
        check("abort ready_after_rst", 32'(ready), 1);
        repeat (12) idle_tick();
        check("abort no_done", done_cnt, 0);
        run_frame(1'b0, 12'h030, 2'd0, 32'h0, 0);
        frame_checks("abort_ram", 1'b0, 2'd0, 1'b0, 32'h3C000000);

        // ---------------- random write / read-back ----------------
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      ra = 12'h800 + 12'($urandom_range(0, 2047));
            else if (r == 1) ra = 12'h7FC + 12'($urandom_range(0, 3));
            else             ra = 12'($urandom_range(0, MW - 1));
            rbl = 2'($urandom);
            rw  = $urandom;
            run_frame(1'b1, ra, rbl, rw, int'($urandom_range(0, 2)));
            frame_checks($sformatf("rnd%0d_w", it), 1'b1, rbl, int'(ra) >= MW, rw);
            model_write(ra, rbl, rw);
            exp = '0;
            for (int j = 0; j <= int'(rbl); j++)
                exp[31 - 8*j -: 8] = (int'(ra) >= MW) ? 8'h00 : mem_model[(int'(ra) + j) % MW];
            run_frame(1'b0, ra, rbl, 32'h0, int'($urandom_range(0, 2)));
            frame_checks($sformatf("rnd%0d_r", it), 1'b0, rbl, int'(ra) >= MW, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
